// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_port_arbiter_if : fetch, load/store and memory-port bundle
// Rev 1.0
// ------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic              ifFlush;
  logic              ifGnt;
  logic              ifRvalid;
  logic [DATA_W-1:0] ifRdata;

  logic              lsReq;
  logic              lsWe;
  logic [ADDR_W-1:0] lsAddr;
  logic [DATA_W-1:0] lsWdata;
  logic [BE_W-1:0]   lsBe;
  logic              lsGnt;
  logic              lsRvalid;
  logic [DATA_W-1:0] lsRdata;

  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [BE_W-1:0]   memBe;
  logic              memReady;
  logic [DATA_W-1:0] memRdata;

  // Arbiter side
  modport slave (
    input  ifReq, ifAddr, ifFlush,
    input  lsReq, lsWe, lsAddr, lsWdata, lsBe,
    input  memReady, memRdata,
    output ifGnt, ifRvalid, ifRdata,
    output lsGnt, lsRvalid, lsRdata,
    output memReq, memWe, memAddr, memWdata, memBe
  );

  // Core pipeline plus memory side
  modport master (
    output ifReq, ifAddr, ifFlush,
    output lsReq, lsWe, lsAddr, lsWdata, lsBe,
    output memReady, memRdata,
    input  ifGnt, ifRvalid, ifRdata,
    input  lsGnt, lsRvalid, lsRdata,
    input  memReq, memWe, memAddr, memWdata, memBe
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_port_arbiter : shares one memory port between fetch and load/store,
// one outstanding transaction; optional fairness via ARB_FAIRNESS_EN. Rev 1.0
// ------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic               clk,
  input  logic               rstN,
  mem_port_arbiter_if.slave  bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              sel_cycle;
  logic              if_elig;
  logic              force_if;
  logic              grant_if;
  logic              grant_ls;
  logic              complete_if;
  logic              complete_ls;
  logic              deliver_if;
  logic              killed;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  if (MAX_LS_STREAK < 1 || MAX_LS_STREAK > 15) begin : g_bad_streak
    $error("MAX_LS_STREAK must lie within 1..15");
  end

  assign if_elig     = bus.ifReq && !bus.ifFlush;
  assign complete_if = (state == BUSY_IF) && bus.memReady;
  assign complete_ls = (state == BUSY_LS) && bus.memReady;
  // A flush on the completion cycle kills the response just like an earlier one
  assign deliver_if  = complete_if && !killed && !bus.ifFlush;

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);
  logic [3:0] streak;

  assign force_if = if_elig && (streak == STREAK_MAX);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      streak <= 4'd0;
    end else if (grant_if) begin
      streak <= 4'd0;
    end else if (grant_ls) begin
      if (!bus.ifReq)
        streak <= 4'd0;
      else if (streak != STREAK_MAX)
        streak <= streak + 4'd1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Selection runs when idle and again on the completion cycle for back-to-back handoff
  always_comb begin
    state_next = state;
    sel_cycle  = 1'b0;
    grant_if   = 1'b0;
    grant_ls   = 1'b0;
    case (state)
      IDLE:             sel_cycle  = 1'b1;
      BUSY_IF, BUSY_LS: sel_cycle  = bus.memReady;
      default:          state_next = IDLE;
    endcase
    if (sel_cycle) begin
      if (bus.lsReq && !force_if) begin
        grant_ls   = 1'b1;
        state_next = BUSY_LS;
      end else if (if_elig) begin
        grant_if   = 1'b1;
        state_next = BUSY_IF;
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      killed <= 1'b0;
    end else if (state == BUSY_IF && !bus.memReady) begin
      if (bus.ifFlush)
        killed <= 1'b1;
    end else begin
      killed <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (grant_ls) begin
      mem_req   <= 1'b1;
      mem_we    <= bus.lsWe;
      mem_addr  <= bus.lsAddr;
      mem_wdata <= bus.lsWdata;
      mem_be    <= bus.lsBe;
    end else if (grant_if) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= bus.ifAddr;
      mem_wdata <= '0;
      mem_be    <= '1;
    end else if (complete_if || complete_ls) begin
      mem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= deliver_if;
      ls_rvalid <= complete_ls;
      if (deliver_if)
        if_rdata <= bus.memRdata;
      // Stores leave the load-data register untouched
      if (complete_ls && !mem_we)
        ls_rdata <= bus.memRdata;
    end
  end

  assign bus.ifGnt    = grant_if;
  assign bus.lsGnt    = grant_ls;
  assign bus.ifRvalid = if_rvalid;
  assign bus.ifRdata  = if_rdata;
  assign bus.lsRvalid = ls_rvalid;
  assign bus.lsRdata  = ls_rdata;
  assign bus.memReq   = mem_req;
  assign bus.memWe    = mem_we;
  assign bus.memAddr  = mem_addr;
  assign bus.memWdata = mem_wdata;
  assign bus.memBe    = mem_be;

endmodule
`default_nettype wire
